// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential 16-byte line fetch into a credit-limited line queue.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the decoder when the queue is empty.
module ifetch_prefetch_buffer #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_address,
  output logic         imem_valid,
  input  logic         imem_ready,
  output logic [31:0]  imem_address,
  input  logic         imem_dp_valid,
  output logic         imem_dp_ready,
  input  logic [127:0] imem_dp_read_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [31:0]  out_address,
  output logic [3:0]   out_offset
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] occ_q, occ_d, outs_q, outs_d, drop_q, drop_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, awr_q, awr_d, ard_q, ard_d;
  logic [31:0]      fetch_q, fetch_d;
  logic [3:0]       poff_q, poff_d;

  logic [127:0] line_q  [DEPTH];
  logic [31:0]  laddr_q [DEPTH];
  logic [3:0]   loff_q  [DEPTH];
  logic [31:0]  raddr_q [DEPTH];
  logic [3:0]   roff_q  [DEPTH];

  logic [CNT_W:0] credit_sum;
  logic accept, resp, resp_live, push, pop, bypass;

  always_comb begin
    credit_sum    = {1'b0, occ_q} + {1'b0, outs_q};
    imem_valid    = !reset && !redirect_valid && (credit_sum < DEPTH_C);
    imem_address  = fetch_q;
    imem_dp_ready = !reset;
    accept        = imem_valid && imem_ready;
    // A response with nothing outstanding can only belong to a pre-reset request.
    resp          = imem_dp_valid && !reset && (outs_q != '0);
    resp_live     = resp && (drop_q == '0) && !redirect_valid;

    out_valid   = 1'b0;
    out_data    = '0;
    out_address = '0;
    out_offset  = '0;
    bypass      = 1'b0;
    if (!reset && !redirect_valid) begin
      if (occ_q != '0) begin
        out_valid   = 1'b1;
        out_data    = line_q[rd_q];
        out_address = laddr_q[rd_q];
        out_offset  = loff_q[rd_q];
      end
`ifdef PREFETCH_BYPASS_EN
      else if (resp_live) begin
        out_valid   = 1'b1;
        out_data    = imem_dp_read_data;
        out_address = raddr_q[ard_q];
        out_offset  = roff_q[ard_q];
        bypass      = 1'b1;
      end
`endif
    end
    pop  = out_valid && out_ready && !bypass;
    push = resp_live && !(bypass && out_ready);
  end

  always_comb begin
    occ_d   = occ_q;
    outs_d  = outs_q;
    drop_d  = drop_q;
    wr_d    = push ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    awr_d   = accept ? awr_q + PTR_ONE : awr_q;
    ard_d   = resp ? ard_q + PTR_ONE : ard_q;
    fetch_d = fetch_q;
    poff_d  = poff_q;

    if (push && !pop)      occ_d = occ_q + CNT_ONE;
    else if (!push && pop) occ_d = occ_q - CNT_ONE;
    if (accept && !resp)      outs_d = outs_q + CNT_ONE;
    else if (!accept && resp) outs_d = outs_q - CNT_ONE;
    if (resp && drop_q != '0) drop_d = drop_q - CNT_ONE;

    if (accept) begin
      fetch_d = fetch_q + 32'd16;
      poff_d  = 4'd0;
    end

    // Every request still in flight after this cycle is stale; no accept can happen here.
    if (redirect_valid) begin
      occ_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      drop_d  = outs_d;
      fetch_d = {redirect_address[31:4], 4'b0};
      poff_d  = redirect_address[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q   <= '0;
      outs_q  <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      awr_q   <= '0;
      ard_q   <= '0;
      fetch_q <= {RESET_VECTOR[31:4], 4'b0};
      poff_q  <= RESET_VECTOR[3:0];
    end else begin
      occ_q   <= occ_d;
      outs_q  <= outs_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      awr_q   <= awr_d;
      ard_q   <= ard_d;
      fetch_q <= fetch_d;
      poff_q  <= poff_d;
    end
  end

  // Storage is not reset; out_* are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      raddr_q[awr_q] <= fetch_q;
      roff_q[awr_q]  <= poff_q;
    end
    if (push) begin
      line_q[wr_q]  <= imem_dp_read_data;
      laddr_q[wr_q] <= raddr_q[ard_q];
      loff_q[wr_q]  <= roff_q[ard_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (credit_sum <= DEPTH_C);
  end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer with a simple in-order memory responder.
module tb_ifetch_prefetch_buffer;
  logic         clk = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [31:0]  redirect_address;
  logic         imem_valid;
  logic         imem_ready;
  logic [31:0]  imem_address;
  logic         imem_dp_valid;
  logic         imem_dp_ready;
  logic [127:0] imem_dp_read_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [31:0]  out_address;
  logic [3:0]   out_offset;

  ifetch_prefetch_buffer #(.DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_address(imem_address),
    .imem_dp_valid(imem_dp_valid), .imem_dp_ready(imem_dp_ready),
    .imem_dp_read_data(imem_dp_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_address(out_address), .out_offset(out_offset)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; logic [3:0] off; logic [127:0] data; int cyc; } pop_t;

  pend_t       pend[$];
  logic [31:0] acc_log[$];
  pop_t        pop_log[$];
  bit          ov_hist[0:255];
  int          cyc;
  int          lat;
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1234};
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_dp_valid     = 1'b1;
      imem_dp_read_data = line_of(pend[0].addr);
    end else begin
      imem_dp_valid     = 1'b0;
      imem_dp_read_data = '0;
    end
    #1;
    if (imem_valid && imem_ready) begin
      acc_log.push_back(imem_address);
      pend.push_back('{imem_address, cyc + lat});
    end
    if (imem_dp_valid) void'(pend.pop_front());
    if (cyc < 256) ov_hist[cyc] = out_valid;
    if (out_valid && out_ready) pop_log.push_back('{out_address, out_offset, out_data, cyc});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic enter_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_address = '0;
    imem_ready = 1'b0; out_ready = 1'b0;
    pend.delete(); acc_log.delete(); pop_log.delete();
    step(); step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 256; i++) ov_hist[i] = 1'b0;
    acc_log.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    enter_reset();
    #1;
    tests_run++;
    if ({imem_valid, imem_dp_ready, out_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl got %b want 000", {imem_valid, imem_dp_ready, out_valid});
    end
    tests_run++;
    if ({out_data, out_address, out_offset} !== '0) begin
      tests_failed++; $display("FAIL reset_data got addr %h off %h want 0", out_address, out_offset);
    end
    release_reset();
    imem_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_valid !== 1'b1 || imem_address !== 32'hFFFF_FFF0 || imem_dp_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release got v=%b a=%h r=%b want 1 fffffff0 1", imem_valid, imem_address, imem_dp_ready);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF0; exp_a[1] = 32'h0; exp_a[2] = 32'h10; exp_a[3] = 32'h20;
    enter_reset(); release_reset();
    lat = 3; imem_ready = 1'b1; out_ready = 1'b1;
    repeat (16) step();
    tests_run++;
    if (acc_log.size() < 4 || pop_log.size() < 4) begin
      tests_failed++; $display("FAIL seq_counts got acc %0d pop %0d want >=4", acc_log.size(), pop_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (acc_log[i] !== exp_a[i] || pop_log[i].addr !== exp_a[i] || pop_log[i].data !== line_of(exp_a[i])
            || pop_log[i].off !== 4'd0) begin
          tests_failed++;
          $display("FAIL seq_line%0d got req %h out %h off %h want %h off 0", i, acc_log[i], pop_log[i].addr, pop_log[i].off, exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    enter_reset(); release_reset();
    lat = 1; imem_ready = 1'b1; out_ready = 1'b0;
    repeat (12) step();
    #1;
    tests_run++;
    if (acc_log.size() !== 4 || imem_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_stall got acc %0d valid %b want 4 0", acc_log.size(), imem_valid);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_address !== 32'hFFFF_FFF0) begin
      tests_failed++; $display("FAIL full_head got v=%b a=%h want 1 fffffff0", out_valid, out_address);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    repeat (6) step();
    #1;
    tests_run++;
    if (acc_log.size() !== 5 || imem_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_one_more got acc %0d valid %b want 5 0", acc_log.size(), imem_valid);
    end else begin
      tests_run++;
      if (acc_log[4] !== 32'h30 || pop_log.size() !== 1) begin
        tests_failed++; $display("FAIL full_next_addr got %h pops %0d want 00000030 1", acc_log[4], pop_log.size());
      end
    end
  endtask

  task automatic test_redirect();
    int stale;
    enter_reset(); release_reset();
    lat = 6; imem_ready = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_address = 32'h0000_1236;
    #1;
    tests_run++;
    if (imem_valid !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_cycle got iv=%b ov=%b want 0 0", imem_valid, out_valid);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (imem_valid !== 1'b1 || imem_address !== 32'h0000_1230) begin
      tests_failed++; $display("FAIL redir_resume got v=%b a=%h want 1 00001230", imem_valid, imem_address);
    end
    repeat (20) step();
    stale = 0;
    foreach (pop_log[i]) if (pop_log[i].addr < 32'h0000_1230) stale++;
    tests_run++;
    if (stale !== 0) begin
      tests_failed++; $display("FAIL redir_stale got %0d stale lines want 0", stale);
    end
    tests_run++;
    if (pop_log.size() < 2 || acc_log.size() < 4) begin
      tests_failed++; $display("FAIL redir_counts got pops %0d acc %0d want >=2 >=4", pop_log.size(), acc_log.size());
    end else begin
      tests_run++;
      if (acc_log[3] !== 32'h0000_1230) begin
        tests_failed++; $display("FAIL redir_req got %h want 00001230", acc_log[3]);
      end
      tests_run++;
      if (pop_log[0].addr !== 32'h0000_1230 || pop_log[0].off !== 4'd6 || pop_log[0].data !== line_of(32'h0000_1230)) begin
        tests_failed++; $display("FAIL redir_first got %h off %h want 00001230 off 6", pop_log[0].addr, pop_log[0].off);
      end
      tests_run++;
      if (pop_log[1].addr !== 32'h0000_1240 || pop_log[1].off !== 4'd0) begin
        tests_failed++; $display("FAIL redir_second got %h off %h want 00001240 off 0", pop_log[1].addr, pop_log[1].off);
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    enter_reset(); release_reset();
    lat = 2; imem_ready = 1'b1; out_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_address = 32'h0000_4000;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    tests_run++;
    if (ov_hist[2] !== 1'b0) begin
      tests_failed++; $display("FAIL same_cyc_out got out_valid %b want 0", ov_hist[2]);
    end
    tests_run++;
    if (pop_log.size() < 2) begin
      tests_failed++; $display("FAIL same_cyc_count got %0d want >=2", pop_log.size());
    end else begin
      tests_run++;
      if (pop_log[0].addr !== 32'h0000_4000 || pop_log[1].addr !== 32'h0000_4010 || pop_log[0].off !== 4'd0) begin
        tests_failed++;
        $display("FAIL same_cyc_lines got %h %h off %h want 00004000 00004010 off 0", pop_log[0].addr, pop_log[1].addr, pop_log[0].off);
      end
    end
  endtask

  task automatic test_reset_midop();
    enter_reset(); release_reset();
    lat = 4; imem_ready = 1'b1; out_ready = 1'b0;
    repeat (6) step();
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_address !== 32'hFFFF_FFF0 || acc_log.size() !== 4) begin
      tests_failed++; $display("FAIL midop_setup got v=%b a=%h acc %0d want 1 fffffff0 4", out_valid, out_address, acc_log.size());
    end
    reset = 1'b1;
    step();
    #1;
    tests_run++;
    if ({imem_valid, imem_dp_ready, out_valid, out_data, out_address, out_offset} !== '0) begin
      tests_failed++; $display("FAIL midop_zero got iv=%b dr=%b ov=%b a=%h want all 0", imem_valid, imem_dp_ready, out_valid, out_address);
    end
    step();
    release_reset();
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_valid !== 1'b1 || imem_address !== 32'hFFFF_FFF0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midop_restart got iv=%b a=%h ov=%b want 1 fffffff0 0", imem_valid, imem_address, out_valid);
    end
    repeat (10) step();
    tests_run++;
    if (pop_log.size() < 2) begin
      tests_failed++; $display("FAIL midop_count got %0d want >=2", pop_log.size());
    end else begin
      tests_run++;
      if (pop_log[0].addr !== 32'hFFFF_FFF0 || pop_log[0].data !== line_of(32'hFFFF_FFF0) || pop_log[1].addr !== 32'h0) begin
        tests_failed++; $display("FAIL midop_lines got %h %h want fffffff0 00000000", pop_log[0].addr, pop_log[1].addr);
      end
    end
  endtask

  task automatic test_latency();
    bit exp_ov [0:5];
    enter_reset(); release_reset();
    lat = 2; out_ready = 1'b1;
    imem_ready = 1'b1; step(); imem_ready = 1'b0;
    repeat (6) step();
`ifdef PREFETCH_BYPASS_EN
    exp_ov = '{0, 0, 1, 0, 0, 0};
`else
    exp_ov = '{0, 0, 0, 1, 0, 0};
`endif
    for (int i = 1; i < 6; i++) begin
      tests_run++;
      if (ov_hist[i] !== exp_ov[i]) begin
        tests_failed++; $display("FAIL latency_c%0d got out_valid %b want %b", i, ov_hist[i], exp_ov[i]);
      end
    end
    tests_run++;
    if (pop_log.size() !== 1) begin
      tests_failed++; $display("FAIL latency_count got %0d want 1", pop_log.size());
    end else begin
      tests_run++;
      if (pop_log[0].data !== line_of(32'hFFFF_FFF0) || pop_log[0].addr !== 32'hFFFF_FFF0) begin
        tests_failed++; $display("FAIL latency_data got %h want %h", pop_log[0].data, line_of(32'hFFFF_FFF0));
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_address = '0;
    imem_ready = 1'b0; imem_dp_valid = 1'b0; imem_dp_read_data = '0;
    out_ready = 1'b0; lat = 3; cyc = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_full();
    test_redirect();
    test_redirect_same_cycle();
    test_reset_midop();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
